// File: rtl/m5_tape_rec.sv
// m5_tape_rec -- cassette-out recorder for the Sord M5 core.
//
// Samples the Z80-driven cassette-out bit, measures the time between edges
// in clk_en_10m7_i ticks, decodes the FSK stream (4 SHORT halves = '1',
// 2 LONG halves = '0', UART-style framing after a SHORT leader) and queues
// the decoded bytes in a small FIFO for the HPS to drain.
//
// Ports
//   clk_i          system clock
//   reset_n_i      synchronous reset, active low
//   clk_en_10m7_i  timing tick for the half-period counter
//   tape_out_i     cassette-out bit, asynchronous to the tick
//   enable_i       record enable; 0 forces the decoder to IDLE (FIFO untouched)
//   byte_o         FIFO head data
//   byte_valid_o   FIFO not empty
//   byte_rd_i      pop the head
//   carrier_o      decoder is in LEADER/START/DATA/STOP
//   frame_err_o    sticky framing error
//   overflow_o     sticky, a decoded byte was dropped on a full FIFO
//   byte_cnt_o     bytes accepted into the FIFO since reset/clear
//   clear_i        clears frame_err_o, overflow_o, byte_cnt_o and the FIFO
//   dbg_state_o    current decoder state (IDLE=0 LEADER=1 START=2 DATA=3 STOP=4)
//
// Handshake: byte_o is valid whenever byte_valid_o=1. Holding byte_rd_i=1 on
// a clock edge where byte_valid_o=1 consumes the head; byte_o/byte_valid_o
// show the next entry from the following cycle. byte_rd_i while empty is
// ignored.

module m5_tape_rec #(
  parameter logic [15:0] SHORT_MAX  = 16'd1400,
  parameter logic [15:0] LONG_MAX   = 16'd2800,
  parameter logic [15:0] TIMEOUT    = 16'd16000,
  parameter logic [8:0]  LEADER_MIN = 9'd256,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        clk_en_10m7_i,
  input  logic        tape_out_i,
  input  logic        enable_i,
  output logic [7:0]  byte_o,
  output logic        byte_valid_o,
  input  logic        byte_rd_i,
  output logic        carrier_o,
  output logic        frame_err_o,
  output logic        overflow_o,
  output logic [15:0] byte_cnt_o,
  input  logic        clear_i,
  output logic [2:0]  dbg_state_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_LEADER = 3'd1, S_START = 3'd2, S_DATA = 3'd3, S_STOP = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    EV_SHORT = 2'd0, EV_LONG = 2'd1, EV_BAD = 2'd2, EV_TMO = 2'd3
  } ev_t;

  // ---------------- input path and half-period measurement ----------------
  logic        r_sync1, r_sync2, r_prev;
  logic [15:0] r_cnt;
  logic        r_ev_valid;
  ev_t         r_ev_kind;
  logic        w_edge;
  ev_t         w_cls;

  assign w_edge = r_sync2 ^ r_prev;

  always_comb begin
    w_cls = EV_BAD;
    if (r_cnt <= SHORT_MAX)     w_cls = EV_SHORT;
    else if (r_cnt <= LONG_MAX) w_cls = EV_LONG;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_prev     <= 1'b0;
      r_cnt      <= 16'd0;
      r_ev_valid <= 1'b0;
      r_ev_kind  <= EV_SHORT;
    end else begin
      r_sync1    <= tape_out_i;
      r_sync2    <= r_sync1;
      r_prev     <= r_sync2;
      r_ev_valid <= 1'b0;
      if (w_edge) begin
        r_ev_valid <= 1'b1;
        r_ev_kind  <= w_cls;
        r_cnt      <= 16'd0;
      end else if (clk_en_10m7_i) begin
        if (r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
        // The counter passes TIMEOUT only once per gap, so this fires once.
        if (r_cnt == TIMEOUT - 16'd1) begin
          r_ev_valid <= 1'b1;
          r_ev_kind  <= EV_TMO;
        end
      end
    end
  end

  // ---------------- bit-cell decoder ----------------
  state_t     r_state, w_state_n;
  logic [1:0] r_half, w_half_n, w_half_c;       // halves seen in current cell
  logic       r_cell_long, w_cell_long_n, w_cell_long_c;
  logic [8:0] r_lead, w_lead_n;
  logic [7:0] r_shift, w_shift_n;
  logic [2:0] r_bit_idx, w_bit_idx_n;
  logic       r_push, w_push_n;
  logic       w_ferr_set;
  logic       w_bit_done, w_bit_val, w_cell_err;

  always_comb begin : cell_decode
    w_bit_done    = 1'b0;
    w_bit_val     = 1'b0;
    w_cell_err    = 1'b0;
    w_half_c      = r_half;
    w_cell_long_c = r_cell_long;
    if (r_ev_valid) begin
      case (r_ev_kind)
        EV_SHORT, EV_LONG: begin
          if (r_half == 2'd0) begin
            w_half_c      = 2'd1;
            w_cell_long_c = (r_ev_kind == EV_LONG);
          end else if ((r_ev_kind == EV_LONG) != r_cell_long) begin
            w_cell_err = 1'b1;
          end else if (r_cell_long) begin
            w_bit_done = 1'b1;
            w_half_c   = 2'd0;
          end else if (r_half == 2'd3) begin
            w_bit_done = 1'b1;
            w_bit_val  = 1'b1;
            w_half_c   = 2'd0;
          end else begin
            w_half_c = r_half + 2'd1;
          end
        end
        EV_BAD:  w_cell_err = 1'b1;
        default: ;
      endcase
    end
  end

  // ---------------- framing FSM ----------------
  always_comb begin : fsm_next
    w_state_n     = r_state;
    w_half_n      = r_half;
    w_cell_long_n = r_cell_long;
    w_lead_n      = r_lead;
    w_shift_n     = r_shift;
    w_bit_idx_n   = r_bit_idx;
    w_push_n      = 1'b0;
    w_ferr_set    = 1'b0;
    if (!enable_i) begin
      w_state_n = S_IDLE;
      w_half_n  = 2'd0;
      w_lead_n  = 9'd0;
    end else if (r_ev_valid) begin
      case (r_state)
        S_IDLE: begin
          w_half_n = 2'd0;
          if (r_ev_kind == EV_SHORT) begin
            if (r_lead == LEADER_MIN - 9'd1) begin
              w_state_n = S_LEADER;
              w_lead_n  = 9'd0;
            end else begin
              w_lead_n = r_lead + 9'd1;
            end
          end else begin
            w_lead_n = 9'd0;
          end
        end
        S_LEADER: begin
          // The first LONG half is already half 1 of the start bit.
          if (r_ev_kind == EV_LONG) begin
            w_state_n     = S_START;
            w_half_n      = 2'd1;
            w_cell_long_n = 1'b1;
          end else if (r_ev_kind != EV_SHORT) begin
            w_state_n = S_IDLE;
          end
        end
        S_START: begin
          w_half_n      = w_half_c;
          w_cell_long_n = w_cell_long_c;
          if (r_ev_kind == EV_TMO || w_cell_err) begin
            w_state_n = S_IDLE;
            w_half_n  = 2'd0;
          end else if (r_half == 2'd0 && r_ev_kind == EV_SHORT) begin
            // SHORT where a start bit should begin: this is a new leader.
            w_state_n = S_LEADER;
            w_half_n  = 2'd0;
          end else if (w_bit_done) begin
            w_state_n   = S_DATA;
            w_bit_idx_n = 3'd0;
          end
        end
        S_DATA: begin
          w_half_n      = w_half_c;
          w_cell_long_n = w_cell_long_c;
          if (r_ev_kind == EV_TMO || w_cell_err) begin
            w_state_n  = S_IDLE;
            w_half_n   = 2'd0;
            w_ferr_set = 1'b1;
          end else if (w_bit_done) begin
            w_shift_n   = {w_bit_val, r_shift[7:1]};
            w_bit_idx_n = r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) w_state_n = S_STOP;
          end
        end
        S_STOP: begin
          w_half_n      = w_half_c;
          w_cell_long_n = w_cell_long_c;
          if (r_ev_kind == EV_TMO || w_cell_err) begin
            w_state_n  = S_IDLE;
            w_half_n   = 2'd0;
            w_ferr_set = 1'b1;
          end else if (w_bit_done) begin
            if (w_bit_val) begin
              w_push_n  = 1'b1;
              w_state_n = S_START;
            end else begin
              w_state_n  = S_IDLE;
              w_ferr_set = 1'b1;
            end
          end
        end
        default: w_state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_state     <= S_IDLE;
      r_half      <= 2'd0;
      r_cell_long <= 1'b0;
      r_lead      <= 9'd0;
      r_shift     <= 8'd0;
      r_bit_idx   <= 3'd0;
      r_push      <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_half      <= w_half_n;
      r_cell_long <= w_cell_long_n;
      r_lead      <= w_lead_n;
      r_shift     <= w_shift_n;
      r_bit_idx   <= w_bit_idx_n;
      r_push      <= w_push_n;
    end
  end

  assign carrier_o   = (r_state != S_IDLE);
  assign dbg_state_o = r_state;

  // ---------------- byte FIFO and status ----------------
  // r_shift is stable in the push cycle: the next data bit is at least a
  // full start bit away.
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr, r_rd, w_rd_n;
  logic [AW:0]   r_count, w_cnt_n, w_cnt_pop;
  logic [7:0]    r_byte, w_head;
  logic          r_valid, r_ferr, r_ovf;
  logic [15:0]   r_bcnt;
  logic          w_pop, w_full, w_push_ok, w_drop;

  assign w_pop     = byte_rd_i && (r_count != '0);
  assign w_full    = (r_count == DEPTH_C);
  assign w_push_ok = r_push && !clear_i && (!w_full || w_pop);
  assign w_drop    = r_push && !clear_i && w_full && !w_pop;
  assign w_rd_n    = w_pop ? r_rd + 1'b1 : r_rd;
  assign w_cnt_pop = w_pop ? r_count - 1'b1 : r_count;
  assign w_cnt_n   = w_push_ok ? w_cnt_pop + 1'b1 : w_cnt_pop;
  // A push into an otherwise empty FIFO becomes the head directly.
  assign w_head    = (w_push_ok && w_cnt_pop == '0) ? r_shift : r_mem[w_rd_n];

  always_ff @(posedge clk_i) begin
    if (w_push_ok) r_mem[r_wr] <= r_shift;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i || clear_i) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_byte  <= 8'd0;
      r_valid <= 1'b0;
      r_bcnt  <= 16'd0;
      r_ovf   <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr   <= r_wr + 1'b1;
        r_bcnt <= r_bcnt + 16'd1;
      end
      r_rd    <= w_rd_n;
      r_count <= w_cnt_n;
      r_byte  <= w_head;
      r_valid <= (w_cnt_n != '0);
      if (w_drop)     r_ovf  <= 1'b1;
      if (w_ferr_set) r_ferr <= 1'b1;
    end
  end

  assign byte_o       = r_byte;
  assign byte_valid_o = r_valid;
  assign byte_cnt_o   = r_bcnt;
  assign overflow_o   = r_ovf;
  assign frame_err_o  = r_ferr;

endmodule
